ows_crc8_checker: RTL and testbench
===================================

// Module: ows_crc8_checker
// PURPOSE
//  Serial Dallas/Maxim CRC-8 engine (x^8+x^5+x^4+1, reflected, init 0x00) downstream of the UID data shifter.
//  Consumes the LSB-first 56-bit family+serial stream, one bit per qualified cycle.
//  Compares the result against the CRC byte UID[63:56] and reports pass/fail to the slave control FSM.
//  Gates ROM-code responses.
// PARAMETERS
//  DATA_BITS   56   number of stream bits covered by the CRC (family + serial)
//  CNT_W       8    width of the internal bit counter (must hold DATA_BITS)
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  rst_n         in   1      asynchronous active-low reset
//  start         in   1      pulse: clear CRC, arm a new check (driven from shifter start_crc rising edge)
//  bit_valid     in   1      bit_in qualifier; one CRC step per high cycle while SHIFT
//  bit_in        in   1      serial data bit, LSB of byte 0 first
//  crc_expected  in   8      reference CRC byte (UID[63:56]); sampled on the start cycle
//  busy          out  1      high in SHIFT and CHECK
//  crc_done      out  1      one-cycle pulse when result valid
//  crc_ok        out  1      1 = computed CRC == expected; held until next start
//  crc_out       out  8      running/final CRC register
//  bit_count     out  CNT_W  bits consumed in current check
// BEHAVIOUR
//  Reset: state=IDLE; crc_out=0x00, bit_count=0, busy=0, crc_done=0, crc_ok=0; expected latch=0x00.
//  CRC step: fb = crc[0]^bit_in; crc_next = {1'b0,crc[7:1]} ^ (fb ? 8'h8C : 8'h00).
//  FSM IDLE -> SHIFT on start.
//   On the start cycle: crc<=0x00, bit_count<=0, crc_ok<=0, latch crc_expected.
//  SHIFT: each cycle with bit_valid=1 applies one CRC step and bit_count+1.
//   bit_valid=0 holds all state; no timeout.
//   The step taking bit_count to DATA_BITS also moves the FSM to CHECK.
//   Bits beyond DATA_BITS are never absorbed.
//  CHECK (1 cycle): crc_ok <= (crc_out==expected); crc_done=1 this cycle only; -> IDLE next cycle.
//  Latency: crc_done asserts exactly 1 cycle after the clock edge consuming bit DATA_BITS-1.
//  IDLE: bit_valid ignored; crc_out, bit_count, crc_ok hold final values.
//  start in SHIFT or CHECK: restarts (same actions as from IDLE).
//   A start coinciding with bit_valid discards that bit.
//   In CHECK, start wins: no crc_done pulse, crc_ok stays 0.
//  rst_n low at any time: immediate return to reset values; any partial check is lost.
//  bit_count saturates at DATA_BITS; never wraps.
// TESTING
//  1 Reset: rst_n low mid-SHIFT (after 20 bits)
//    -> all outputs at reset values asynchronously; after release, IDLE and no crc_done.
//  2 Known vector: start, expected=0xA2; stream bytes 02,1C,B8,01,00,00,00 LSB-first
//    with continuous bit_valid.
//    -> crc_out=0xA2; crc_done 1 cycle after bit 55; crc_ok=1.
//  3 Mismatch: same stream, expected=0xA3
//    -> crc_done pulse, crc_ok=0, crc_out=0xA2.
//  4 Gapped valid: vector of 2 with bit_valid low 3 cycles between every bit
//    -> same result; bit_count steps only on valid; done 1 cycle after last valid.
//  5 All-zero stream, expected=0x00 -> crc_out=0x00, crc_ok=1.
//    Then 10 extra bit_valid=1 bits in IDLE -> crc_out and bit_count unchanged.
//  6 Restart: start after 30 bits, then full vector of 2
//    -> crc_done exactly once with crc_ok=1.
//    Also: start in the CHECK cycle -> no crc_done pulse, busy stays 1.

Source files
------------

// File: rtl/ows_crc8_checker.sv
// ows_crc8_checker: serial Dallas/Maxim CRC-8 over the LSB-first 56-bit UID stream,
// compared against the UID CRC byte to qualify ROM-code responses.
module ows_crc8_checker #(
    parameter int DATA_BITS = 56,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic [7:0]       crc_expected,
    output logic             busy,
    output logic             crc_done,
    output logic             crc_ok,
    output logic [7:0]       crc_out,
    output logic [CNT_W-1:0] bit_count
);
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_BITS);
    state_t     state, state_next;
    logic [7:0] expected;
    logic [7:0] crc_step;
    logic       step;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    always_comb begin
        step       = state == SHIFT && bit_valid && !start && bit_count != FULL;
        state_next = start ? SHIFT :
                     state == CHECK ? IDLE :
                     step && bit_count == FULL - 1'b1 ? CHECK : state;
        busy       = state != IDLE;
        crc_done   = state == CHECK && !start;
        crc_step   = {1'b0, crc_out[7:1]} ^ ((crc_out[0] ^ bit_in) ? 8'h8C : 8'h00);
    end
    // start has priority: it discards a coincident bit and suppresses the CHECK verdict
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            crc_out   <= '0;
            bit_count <= '0;
            crc_ok    <= 1'b0;
            expected  <= '0;
        end else if (start) begin
            crc_out   <= '0;
            bit_count <= '0;
            crc_ok    <= 1'b0;
            expected  <= crc_expected;
        end else if (step) begin
            crc_out   <= crc_step;
            bit_count <= bit_count + 1'b1;
        end else if (state == CHECK) begin
            crc_ok    <= crc_out == expected;
        end
endmodule

// File: tb/tb_ows_crc8_checker.sv
// tb_ows_crc8_checker: randomized and directed checks of the CRC-8 checker against a
// polynomial long-division reference model.
module tb_ows_crc8_checker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic [7:0]  crc_expected = 8'h00;
    logic        busy, crc_done, crc_ok;
    logic [7:0]  crc_out;
    logic [7:0]  bit_count;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    localparam logic [55:0] VEC = 56'h00_0000_01B8_1C02;

    ows_crc8_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
        .crc_expected(crc_expected), .busy(busy), .crc_done(crc_done), .crc_ok(crc_ok),
        .crc_out(crc_out), .bit_count(bit_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (crc_done) done_cnt++;

    // message * x^8 mod (x^8+x^5+x^4+1), first stream bit as the highest power, result bit-reversed
    function automatic logic [7:0] model_crc(input logic [55:0] data);
        logic [63:0] v;
        logic [7:0]  r;
        v = '0;
        for (int k = 0; k < 56; k++) v = {v[62:0], data[k]};
        v = v << 8;
        for (int i = 63; i >= 8; i--) if (v[i]) v = v ^ (64'h131 << (i - 8));
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    task automatic start_check(input logic [7:0] exp);
        @(negedge clk);
        start = 1'b1;
        crc_expected = exp;
        bit_valid = 1'($urandom_range(0, 1));
        bit_in = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic feed(input logic [55:0] data, input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            if (k > 0)
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    bit_valid = 1'b0;
                    bit_in = 1'($urandom_range(0, 1));
                    checks++;
                    if (bit_count !== 8'(k)) begin
                        errors++;
                        $display("FAIL gap_count bit %0d got %0d want %0d", k, bit_count, k);
                    end
                end
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in = data[k];
        end
    endtask

    task automatic finish_check(input string name, input logic [55:0] data, input logic [7:0] exp);
        logic [7:0] m;
        m = model_crc(data);
        @(negedge clk);
        bit_valid = 1'b0;
        checks++;
        if (crc_done !== 1'b1 || crc_out !== m || bit_count !== 8'd56 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_done got done=%b crc=%h cnt=%0d busy=%b want done=1 crc=%h cnt=56 busy=1",
                     name, crc_done, crc_out, bit_count, busy, m);
        end
        @(negedge clk);
        checks++;
        if (crc_done !== 1'b0 || busy !== 1'b0 || crc_ok !== (m == exp) || crc_out !== m) begin
            errors++;
            $display("FAIL %s_result got done=%b busy=%b ok=%b crc=%h want done=0 busy=0 ok=%b crc=%h",
                     name, crc_done, busy, crc_ok, crc_out, m == exp, m);
        end
    endtask

    task automatic test_reset;
        int d;
        #1;
        checks++;
        if (busy !== 0 || crc_done !== 0 || crc_ok !== 0 || crc_out !== 0 || bit_count !== 0) begin
            errors++;
            $display("FAIL por got busy=%b done=%b ok=%b crc=%h cnt=%0d want all 0", busy, crc_done, crc_ok, crc_out, bit_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_check(8'hA2);
        feed(VEC, 20, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 0 || crc_done !== 0 || crc_ok !== 0 || crc_out !== 0 || bit_count !== 0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b ok=%b crc=%h cnt=%0d want all 0", busy, crc_done, crc_ok, crc_out, bit_count);
        end
        @(negedge clk);
        bit_valid = 1'b0;
        rst_n = 1'b1;
        d = done_cnt;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 0 || done_cnt !== d || bit_count !== 0) begin
            errors++;
            $display("FAIL post_reset got busy=%b dones=%0d cnt=%0d want busy=0 dones=%0d cnt=0", busy, done_cnt, bit_count, d);
        end
    endtask

    task automatic test_known;
        checks++;
        if (model_crc(VEC) !== 8'hA2) begin
            errors++;
            $display("FAIL model_vector got %h want a2", model_crc(VEC));
        end
        start_check(8'hA2);
        feed(VEC, 56, 0);
        finish_check("known", VEC, 8'hA2);
    endtask

    task automatic test_mismatch;
        start_check(8'hA3);
        feed(VEC, 56, 0);
        finish_check("mismatch", VEC, 8'hA3);
    endtask

    task automatic test_gapped;
        start_check(8'hA2);
        feed(VEC, 56, 3);
        finish_check("gapped", VEC, 8'hA2);
    endtask

    task automatic test_zero_idle;
        logic [7:0] c;
        logic [7:0] n;
        start_check(8'h00);
        feed('0, 56, 0);
        finish_check("zero", '0, 8'h00);
        c = crc_out;
        n = bit_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bit_valid = 1'b0;
        checks++;
        if (crc_out !== c || bit_count !== n || busy !== 1'b0 || crc_ok !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold got crc=%h cnt=%0d busy=%b ok=%b want crc=%h cnt=%0d busy=0 ok=1", crc_out, bit_count, busy, crc_ok, c, n);
        end
    endtask

    task automatic test_restart;
        int d;
        start_check(8'h55);
        feed(VEC, 30, 0);
        d = done_cnt;
        start_check(8'hA2);
        feed(VEC, 56, 0);
        finish_check("restart", VEC, 8'hA2);
        checks++;
        if (done_cnt !== d + 1) begin
            errors++;
            $display("FAIL restart_dones got %0d want %0d", done_cnt - d, 1);
        end
        start_check(8'hA2);
        feed(VEC, 56, 0);
        d = done_cnt;
        @(negedge clk);
        start = 1'b1;
        bit_valid = 1'b0;
        #1;
        checks++;
        if (crc_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL check_start got done=%b busy=%b want done=0 busy=1", crc_done, busy);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || crc_ok !== 1'b0 || bit_count !== 0 || crc_out !== 0 || done_cnt !== d) begin
            errors++;
            $display("FAIL check_restart got busy=%b ok=%b cnt=%0d crc=%h dones=%0d want busy=1 ok=0 cnt=0 crc=00 dones=%0d",
                     busy, crc_ok, bit_count, crc_out, done_cnt, d);
        end
        feed(VEC, 56, 0);
        finish_check("after_check_start", VEC, 8'hA2);
    endtask

    task automatic test_random;
        logic [55:0] data;
        logic [7:0]  exp;
        for (int t = 0; t < 8; t++) begin
            data = {24'($urandom), $urandom};
            exp = $urandom_range(0, 1) ? model_crc(data) : 8'($urandom);
            start_check(exp);
            feed(data, 56, $urandom_range(0, 2));
            finish_check("random", data, exp);
        end
    endtask

    initial begin
        test_reset;
        test_known;
        test_mismatch;
        test_gapped;
        test_zero_idle;
        test_restart;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
